instr_loader: RTL and testbench

Serial program loader for the single-clock MIPS core: the write-side counterpart of the instruction memory that the PC/fetch path reads. It accepts a framed byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them through the instruction memory write port at consecutive word addresses. It verifies an XOR checksum and holds the core stalled via `cpu_run` until a load completes cleanly.

---
 rtl/instr_loader.sv | 172 +++++++++++++++++
 tb/tb_instr_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Serial program loader: assembles big-endian words from a framed byte stream, writes them
// to instruction memory at consecutive addresses and releases the core on a clean checksum.
module instr_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic        cpu_run,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        StIdle, StLenHi, StLenLo, StData, StWrite, StCheck, StDone, StErr
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [23:0] word_q, word_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  acc_q, acc_d;
    logic [15:0] count_q, count_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        run_q, run_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        xfer;
    logic [15:0] len_n;
    logic [15:0] count_inc;

    assign rx_ready   = (state_q == StLenHi) || (state_q == StLenLo) ||
                        (state_q == StData)  || (state_q == StCheck);
    assign busy       = (state_q != StIdle) && (state_q != StDone) && (state_q != StErr);
    assign xfer       = rx_valid && rx_ready;
    assign len_n      = {len_q[15:8], rx_data};
    assign count_inc  = count_q + 16'd1;

    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign cpu_run    = run_q;
    assign done       = done_q;
    assign error      = err_q;
    assign word_count = count_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        word_d  = word_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        run_d   = run_q;
        done_d  = done_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    count_d = '0;
                    acc_d   = '0;
                    idx_d   = '0;
                    run_d   = 1'b0;
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    len_d   = {rx_data, 8'h00};
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (xfer) begin
                    len_d = len_n;
                    if (len_n == 16'd0) begin
                        state_d = StCheck;
                    end else if ({16'd0, len_n} > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    acc_d = acc_q ^ rx_data;
                    idx_d = idx_q + 2'd1;
                    unique case (idx_q)
                        2'd0: word_d[23:16] = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[7:0]   = rx_data;
                        2'd3: begin
                            // Address uses the pre-increment count; it advances at the end of WRITE.
                            we_d    = 1'b1;
                            addr_d  = BASE_ADDR + {14'd0, count_q, 2'b00};
                            data_d  = {word_q, rx_data};
                            state_d = StWrite;
                        end
                    endcase
                end
            end
            StWrite: begin
                count_d = count_inc;
                state_d = (count_inc == len_q) ? StCheck : StData;
            end
            StCheck: begin
                if (xfer) begin
                    if (rx_data == acc_q) begin
                        done_d  = 1'b1;
                        run_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StErr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: a frame-level model queues expected memory writes and
// final status; a negedge monitor pops and compares every write strobe.
module tb_instr_loader;

    localparam logic [31:0] BASE = 32'h0000_0000;
    localparam int unsigned MAX  = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, mem_we, cpu_run, busy, done, error;
    logic [31:0] mem_addr, mem_data;
    logic [15:0] word_count;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    bit gaps_en = 1'b0;
    bit start_noise = 1'b0;
    logic [63:0] sb[$];
    logic [31:0] words[0:15];

    instr_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAX)) dut (
        .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .cpu_run(cpu_run), .busy(busy), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!reset && mem_we) begin
            if (sb.size() == 0) begin
                check("unexpected write addr", mem_addr, 32'hFFFF_FFFF);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("write addr", mem_addr, e[63:32]);
                check("write data", mem_data, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit took = 1'b0;
        if (gaps_en) begin
            repeat ($urandom_range(0, 2)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                tick();
            end
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int g = 0; g < 50 && !took; g++) begin
            start = start_noise && ($urandom_range(0, 3) == 0);
            @(negedge clk);
            took = rx_ready;
            tick();
            start = 1'b0;
        end
        if (!took) check("byte accept timeout", 32'd0, 32'd1);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start(output int c0);
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        check("busy after start", {31'd0, busy}, 32'd1);
        check("cpu_run after start", {31'd0, cpu_run}, 32'd0);
        check("rx_ready after start", {31'd0, rx_ready}, 32'd1);
    endtask

    task automatic run_frame(input int n, input bit bad, input bit timed);
        logic [7:0] cks = 8'h00;
        logic [7:0] sent;
        logic [15:0] nl;
        int c0;
        nl = 16'(n);
        if (n <= int'(MAX)) begin
            for (int i = 0; i < n; i++) begin
                sb.push_back({BASE + 32'(4 * i), words[i]});
                cks = cks ^ words[i][31:24] ^ words[i][23:16] ^ words[i][15:8] ^ words[i][7:0];
            end
        end
        pulse_start(c0);
        send_byte(nl[15:8]);
        send_byte(nl[7:0]);
        if (n > int'(MAX)) begin
            check("oversize error", {31'd0, error}, 32'd1);
            check("oversize done", {31'd0, done}, 32'd0);
            check("oversize busy", {31'd0, busy}, 32'd0);
            check("oversize rx_ready", {31'd0, rx_ready}, 32'd0);
            check("oversize word_count", {16'd0, word_count}, 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int b = 3; b >= 0; b--) send_byte(8'(words[i] >> (8 * b)));
        end
        sent = bad ? ((cks == 8'h27) ? 8'h00 : ~cks) : cks;
        send_byte(sent);
        if (timed) check("load cycles", 32'(cyc - c0), 32'(5 * n + 3));
        check("done", {31'd0, done}, {31'd0, !bad});
        check("error", {31'd0, error}, {31'd0, bad});
        check("cpu_run", {31'd0, cpu_run}, {31'd0, !bad});
        check("busy end", {31'd0, busy}, 32'd0);
        check("word_count", {16'd0, word_count}, 32'(n));
        check("writes outstanding", 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, " mem_we"}, {31'd0, mem_we}, 32'd0);
        check({tag, " mem_addr"}, mem_addr, 32'd0);
        check({tag, " mem_data"}, mem_data, 32'd0);
        check({tag, " cpu_run"}, {31'd0, cpu_run}, 32'd0);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
        check({tag, " error"}, {31'd0, error}, 32'd0);
        check({tag, " word_count"}, {16'd0, word_count}, 32'd0);
    endtask

    initial begin
        int c0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_values("reset");
        // Idle: offered bytes are refused.
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle rx_ready", {31'd0, rx_ready}, 32'd0);
            tick();
        end
        rx_valid = 1'b0;

        words[0] = 32'h2002_0005;
        words[1] = 32'h0000_0000;
        run_frame(2, 1'b0, 1'b1);
        run_frame(2, 1'b1, 1'b0);
        run_frame(0, 1'b0, 1'b1);
        run_frame(int'(MAX) + 1, 1'b0, 1'b0);

        // Gapped 3-word loads with start noise mid-load.
        gaps_en     = 1'b1;
        start_noise = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) words[i] = $urandom;
            run_frame(3, r == 2, 1'b0);
        end
        gaps_en     = 1'b0;
        start_noise = 1'b0;

        // Reset after six data bytes; only the first word reaches memory.
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        sb.push_back({BASE, words[0]});
        pulse_start(c0);
        send_byte(8'h00);
        send_byte(8'h03);
        for (int k = 0; k < 6; k++) send_byte(8'(words[k / 4] >> (8 * (3 - k % 4))));
        reset = 1'b1;
        tick();
        check_reset_values("mid reset");
        reset = 1'b0;
        check("abort writes outstanding", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 5; i++) words[i] = $urandom;
        run_frame(5, 1'b0, 1'b1);

        tick();
        tick();
        check("final writes outstanding", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
